// File: rtl/nios_system_cam_ctrl_out.sv
// Avalon-MM camera control output port: level register plus one-shot pulse engine.
// Optional macro CAM_OUT_SETCLR_EN enables the OUTSET/OUTCLEAR writes at addr2/addr3.
module nios_system_cam_ctrl_out #(
  parameter int               WIDTH       = 15,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               PULSE_LEN   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port,
  output logic             pulse_busy
);

  localparam int CW = $clog2(PULSE_LEN + 1);
  localparam logic [CW-1:0] RELOAD = CW'(PULSE_LEN - 1);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] level_q, level_d;
  logic [WIDTH-1:0] pulse_q, pulse_d;
  logic [31:0]      readdata_q, readdata_d;

  logic             write_en;
  logic [WIDTH-1:0] wmask;
  logic             unused_ok;

  assign write_en  = chipselect & ~write_n;
  assign wmask     = writedata[WIDTH-1:0];
  assign unused_ok = &{1'b0, writedata[31:WIDTH]};

  always_comb begin
    level_d = level_q;
    if (write_en) begin
      case (address)
        2'd0: level_d = wmask;
`ifdef CAM_OUT_SETCLR_EN
        2'd2: level_d = level_q | wmask;
        2'd3: level_d = level_q & ~wmask;
`endif
        default: level_d = level_q;
      endcase
    end
  end

  // A PULSE write always beats expiry, so merged pulses show no gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = pulse_q;
    if (write_en && address == 2'd1) begin
      if (state_q == ACTIVE) begin
        pulse_d = pulse_q | wmask;
        cnt_d   = RELOAD;
      end else if (wmask != '0) begin
        pulse_d = wmask;
        cnt_d   = RELOAD;
        state_d = ACTIVE;
      end
    end else if (state_q == ACTIVE) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        pulse_d = '0;
        state_d = IDLE;
      end
    end
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0: readdata_d[WIDTH-1:0] = level_q;
      2'd1: begin
        readdata_d[WIDTH-1:0] = pulse_q;
        readdata_d[31]        = (state_q == ACTIVE);
      end
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      level_q    <= RESET_VALUE;
      pulse_q    <= '0;
      readdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      pulse_q    <= pulse_d;
      readdata_q <= readdata_d;
    end
  end

  assign out_port   = level_q | pulse_q;
  assign pulse_busy = (state_q == ACTIVE);
  assign readdata   = readdata_q;

endmodule

// File: tb/tb_nios_system_cam_ctrl_out.sv
// Self-checking bench for nios_system_cam_ctrl_out using a per-cycle vector table.
// Expected set/clear results follow whether CAM_OUT_SETCLR_EN is defined.
module tb_nios_system_cam_ctrl_out;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [14:0] out_port;
  logic        pulse_busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  nios_system_cam_ctrl_out #(
    .WIDTH(15),
    .RESET_VALUE(15'h0003),
    .PULSE_LEN(4)
  ) dut (
    .clk(clk),
    .reset(reset),
    .address(address),
    .chipselect(chipselect),
    .write_n(write_n),
    .writedata(writedata),
    .readdata(readdata),
    .out_port(out_port),
    .pulse_busy(pulse_busy)
  );

`ifdef CAM_OUT_SETCLR_EN
  localparam logic [14:0] OUT_SET = 15'h0011;
  localparam logic [14:0] OUT_CLR = 15'h0001;
`else
  localparam logic [14:0] OUT_SET = 15'h0010;
  localparam logic [14:0] OUT_CLR = 15'h0010;
`endif
  localparam logic [14:0] LVL = OUT_CLR;

  typedef struct {
    logic        rst;
    logic        cs;
    logic        wn;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [14:0] exp_out;
    logic        exp_busy;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic cs, logic wn, logic [1:0] addr,
                              logic [31:0] wdata, logic [14:0] exp_out,
                              logic exp_busy, logic chk_rd, logic [31:0] exp_rd);
    vec_t v;
    v.rst = rst; v.cs = cs; v.wn = wn; v.addr = addr; v.wdata = wdata;
    v.exp_out = exp_out; v.exp_busy = exp_busy; v.chk_rd = chk_rd; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic checkOutput(string name, vec_t v);
    n_checks++;
    if (out_port !== v.exp_out) begin
      n_errors++;
      $display("[TB] FAIL %s out_port got %h expected %h", name, out_port, v.exp_out);
    end
    n_checks++;
    if (pulse_busy !== v.exp_busy) begin
      n_errors++;
      $display("[TB] FAIL %s pulse_busy got %b expected %b", name, pulse_busy, v.exp_busy);
    end
    if (v.chk_rd) begin
      n_checks++;
      if (readdata !== v.exp_rd) begin
        n_errors++;
        $display("[TB] FAIL %s readdata got %h expected %h", name, readdata, v.exp_rd);
      end
    end
  endtask

  // One vector = one clock: drive on the falling edge, check 1ns after the rising edge.
  task automatic applyStimulus(string name, vec_t v);
    @(negedge clk);
    reset      = v.rst;
    chipselect = v.cs;
    write_n    = v.wn;
    address    = v.addr;
    writedata  = v.wdata;
    @(posedge clk);
    #1;
    checkOutput(name, v);
  endtask

  initial begin
    reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;

    // reset and readback of RESET_VALUE
    vecs.push_back(mk(1, 0, 1, 0, 32'h0, 15'h0003, 0, 1, 32'h0));
    vecs.push_back(mk(1, 0, 1, 0, 32'h0, 15'h0003, 0, 1, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 15'h0003, 0, 1, 32'h0000_0003));
    // DATA write with truncation
    vecs.push_back(mk(0, 1, 0, 0, 32'h0000_ABCD, 15'h2BCD, 0, 1, 32'h0000_0003));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 15'h2BCD, 0, 1, 32'h0000_2BCD));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0000_0010, 15'h0010, 0, 1, 32'h0000_2BCD));
    // OUTSET / OUTCLEAR
    vecs.push_back(mk(0, 1, 0, 2, 32'h0000_0001, OUT_SET, 0, 1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 3, 32'h0000_0010, OUT_CLR, 0, 1, 32'h0));
    vecs.push_back(mk(0, 1, 1, 2, 32'h0, LVL, 0, 1, 32'h0));
    // single pulse on bit2, exactly 4 cycles
    vecs.push_back(mk(0, 1, 0, 1, 32'h0000_0004, LVL | 15'h0004, 1, 1, 32'h0));
    vecs.push_back(mk(0, 1, 1, 1, 32'h0, LVL | 15'h0004, 1, 1, 32'h8000_0004));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0, LVL | 15'h0004, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0, LVL | 15'h0004, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0, LVL, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 1, 32'h0, LVL, 0, 1, 32'h0));
    // pulse on bit0, second write on the expiry cycle merges
    vecs.push_back(mk(0, 1, 0, 1, 32'h0000_0001, LVL | 15'h0001, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0, LVL | 15'h0001, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0, LVL | 15'h0001, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 1, 32'h0, LVL | 15'h0001, 1, 0, 32'h0));
    vecs.push_back(mk(0, 1, 0, 1, 32'h0000_0002, LVL | 15'h0003, 1, 1, 32'h8000_0001));
    vecs.push_back(mk(0, 1, 1, 1, 32'h0, LVL | 15'h0003, 1, 1, 32'h8000_0003));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0, LVL | 15'h0003, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0, LVL | 15'h0003, 1, 0, 32'h0));
    vecs.push_back(mk(0, 0, 1, 0, 32'h0, LVL, 0, 0, 32'h0));
    // zero-mask pulse is ignored, upper writedata bits ignored
    vecs.push_back(mk(0, 1, 0, 1, 32'h0, LVL, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 1, 32'h0, LVL, 0, 1, 32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'hFFFF_8000, 15'h0000, 0, 0, 32'h0));
    vecs.push_back(mk(0, 1, 1, 0, 32'h0, 15'h0000, 0, 1, 32'h0));
    // write without chipselect must not land
    vecs.push_back(mk(0, 0, 0, 0, 32'h0000_1234, 15'h0000, 0, 0, 32'h0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus($sformatf("vec%0d", i), vecs[i]);
    end

    // reset in the middle of a pulse, with a simultaneous PULSE write
    applyStimulus("rst_lvl", mk(0, 1, 0, 0, 32'h0000_7FFF, 15'h7FFF, 0, 0, 32'h0));
    applyStimulus("rst_pulse", mk(0, 1, 0, 1, 32'h0000_0004, 15'h7FFF, 1, 0, 32'h0));
    applyStimulus("rst_mid", mk(0, 1, 1, 1, 32'h0, 15'h7FFF, 1, 1, 32'h8000_0004));
    applyStimulus("rst_hit", mk(1, 1, 0, 1, 32'h0000_0100, 15'h0003, 0, 1, 32'h0));
    applyStimulus("rst_after", mk(0, 1, 1, 1, 32'h0, 15'h0003, 0, 1, 32'h0));
    applyStimulus("rst_after2", mk(0, 0, 1, 0, 32'h0, 15'h0003, 0, 0, 32'h0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
